az_to_poly: RTL and testbench

AZ_TO_POLY -- requirements
Module: az_to_poly

---
 rtl/az_to_poly_pkg.sv | 31 +++
 rtl/az_to_poly_sat_addsub16.sv | 35 +++
 rtl/az_to_poly.sv | 186 ++++++++++++++++++
 tb/tb_az_to_poly.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/az_to_poly_pkg.sv
// az_to_poly_pkg
// Shared constants and state encoding for the LPC-to-polynomial converter.
//   M            : LPC order (a[0..M])
//   NC           : number of coefficients computed per polynomial after f[0]
//   F0_BASE      : unscaled value of f1[0] / f2[0] (1.0 in Q11)
//   F2_BASE_ADDR : write-address offset of the f2 coefficient block
package az_to_poly_pkg;

    localparam int          M            = 10;
    localparam int          NC           = 5;
    localparam logic [15:0] F0_BASE      = 16'd2048;
    localparam logic [3:0]  F2_BASE_ADDR = 4'd8;

    typedef enum logic [3:0] {
        INIT = 4'd0,
        WR0A = 4'd1,
        WR0B = 4'd2,
        RD1  = 4'd3,
        RD2  = 4'd4,
        CALC = 4'd5,
        WR1  = 4'd6,
        WR2  = 4'd7,
        DONE = 4'd8
    } state_t;

    // f1[0] = f2[0] = 2048 >> s (s = 0 -> /2 path, s = 1 -> /4 path)
    function automatic logic [15:0] f0_value(input logic s);
        return F0_BASE >> s;
    endfunction

endpackage

// File: rtl/az_to_poly_sat_addsub16.sv
// sat_addsub16
// Combinational saturating add/subtract producing a 16-bit signed result.
//   a   : 17-bit signed operand (already scaled, so it fits 16 bits in practice)
//   b   : 16-bit signed operand
//   sub : 1 -> y = a - b, 0 -> y = a + b
//   y   : result clamped to [-32768, 32767]
//   sat : high when clamping occurred
module sat_addsub16 (
    input  logic signed [16:0] a,
    input  logic signed [15:0] b,
    input  logic               sub,
    output logic signed [15:0] y,
    output logic               sat
);

    logic signed [17:0] ax;
    logic signed [17:0] bx;
    logic signed [17:0] full;

    always_comb begin
        ax   = {a[16], a};
        bx   = {{2{b[15]}}, b};
        full = sub ? (ax - bx) : (ax + bx);
        // Result fits in 16 bits only if the top three bits agree.
        sat  = (full[17:15] != 3'b000) && (full[17:15] != 3'b111);
        if (!sat) begin
            y = full[15:0];
        end else if (full[17]) begin
            y = 16'sh8000;
        end else begin
            y = 16'sh7FFF;
        end
    end

endmodule

// File: rtl/az_to_poly.sv
// az_to_poly
// Converts LPC coefficients a[1..10] (Q12) into the two symmetric/antisymmetric
// polynomial coefficient sets f1[0..5] and f2[0..5]. Coefficients are first
// computed with /2 scaling; if any result saturates the pass restarts with /4
// scaling and ovf is raised so the downstream evaluator uses the Chebps_10 path.
//
// Control: start is a single-cycle request sampled only in INIT; done is a
// single-cycle completion pulse; every cycle fWrite is high one coefficient
// (fAddr, fOut) is written. There is no back-pressure.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   start     : conversion request pulse
//   aAddr     : LPC memory read address (data returns on aIn one cycle later)
//   aIn       : LPC read data, Q12
//   fAddr     : coefficient write address (0-5 f1, 8-13 f2)
//   fOut      : coefficient write data
//   fWrite    : coefficient write strobe
//   ovf       : /4 scaling was used for this conversion
//   done      : conversion-complete pulse
//   dbg_state : current FSM state encoding
module az_to_poly
    import az_to_poly_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] aIn,
    output logic [3:0]  aAddr,
    output logic [3:0]  fAddr,
    output logic [15:0] fOut,
    output logic        fWrite,
    output logic        ovf,
    output logic        done,
    output logic [3:0]  dbg_state
);

    state_t             state;
    logic               s;
    logic [2:0]         i;
    logic signed [15:0] p;
    logic signed [15:0] f1prev;
    logic signed [15:0] f2prev;

    // CALC datapath: q is taken straight from aIn in the CALC cycle.
    logic signed [16:0] pe;
    logic signed [16:0] qe;
    logic signed [16:0] sum_e;
    logic signed [16:0] dif_e;
    logic signed [16:0] xs;
    logic signed [16:0] xd;
    logic signed [15:0] f1n;
    logic signed [15:0] f2n;
    logic               f1_sat;
    logic               f2_sat;
    logic               calc_sat;

    always_comb begin
        pe    = {p[15], p};
        qe    = {aIn[15], aIn};
        sum_e = pe + qe;
        dif_e = pe - qe;
        // Arithmetic shift gives floor division; the halved sum of two
        // 16-bit values always fits back in 16 bits.
        xs    = s ? (sum_e >>> 2) : (sum_e >>> 1);
        xd    = s ? (dif_e >>> 2) : (dif_e >>> 1);
    end

    sat_addsub16 u_f1 (
        .a   (xs),
        .b   (f1prev),
        .sub (1'b1),
        .y   (f1n),
        .sat (f1_sat)
    );

    sat_addsub16 u_f2 (
        .a   (xd),
        .b   (f2prev),
        .sub (1'b0),
        .y   (f2n),
        .sat (f2_sat)
    );

    assign calc_sat  = f1_sat | f2_sat;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= INIT;
            s      <= 1'b0;
            i      <= 3'd0;
            p      <= '0;
            f1prev <= '0;
            f2prev <= '0;
            aAddr  <= '0;
            fAddr  <= '0;
            fOut   <= '0;
            fWrite <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            fWrite <= 1'b0;
            done   <= 1'b0;
            case (state)
                INIT: begin
                    if (start) begin
                        s      <= 1'b0;
                        ovf    <= 1'b0;
                        i      <= 3'd0;
                        f1prev <= f0_value(1'b0);
                        f2prev <= f0_value(1'b0);
                        fWrite <= 1'b1;
                        fAddr  <= 4'd0;
                        fOut   <= f0_value(1'b0);
                        state  <= WR0A;
                    end
                end
                WR0A: begin
                    fWrite <= 1'b1;
                    fAddr  <= F2_BASE_ADDR;
                    fOut   <= f0_value(s);
                    state  <= WR0B;
                end
                WR0B: begin
                    aAddr <= 4'(i) + 4'd1;
                    state <= RD1;
                end
                RD1: begin
                    aAddr <= 4'(M) - 4'(i);
                    state <= RD2;
                end
                RD2: begin
                    p     <= aIn;
                    state <= CALC;
                end
                CALC: begin
                    if (calc_sat && !s) begin
                        // Restart the whole pass with /4 scaling.
                        s      <= 1'b1;
                        ovf    <= 1'b1;
                        i      <= 3'd0;
                        f1prev <= f0_value(1'b1);
                        f2prev <= f0_value(1'b1);
                        fWrite <= 1'b1;
                        fAddr  <= 4'd0;
                        fOut   <= f0_value(1'b1);
                        state  <= WR0A;
                    end else begin
                        f1prev <= f1n;
                        f2prev <= f2n;
                        fWrite <= 1'b1;
                        fAddr  <= 4'(i) + 4'd1;
                        fOut   <= f1n;
                        state  <= WR1;
                    end
                end
                WR1: begin
                    // f2prev already holds the value computed in CALC.
                    fWrite <= 1'b1;
                    fAddr  <= F2_BASE_ADDR + 4'(i) + 4'd1;
                    fOut   <= f2prev;
                    state  <= WR2;
                end
                WR2: begin
                    if (i == 3'(NC - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i     <= i + 3'd1;
                        aAddr <= 4'(i) + 4'd2;
                        state <= RD1;
                    end
                end
                DONE: begin
                    state <= INIT;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_az_to_poly.sv
module tb_az_to_poly;
    import az_to_poly_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] aIn = 16'd0;
    logic [3:0]  aAddr;
    logic [3:0]  fAddr;
    logic [15:0] fOut;
    logic        fWrite;
    logic        ovf;
    logic        done;
    logic [3:0]  dbg_state;

    logic [15:0] a_mem [0:15];
    logic [19:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          done_count = 0;

    az_to_poly dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .aIn       (aIn),
        .aAddr     (aAddr),
        .fAddr     (fAddr),
        .fOut      (fOut),
        .fWrite    (fWrite),
        .ovf       (ovf),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    // LPC memory: read data returns one cycle after the address.
    always @(posedge clk) aIn <= a_mem[aAddr];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every coefficient write must match the head of exp_q.
    always @(negedge clk) begin
        if (fWrite) begin
            wr_count = wr_count + 1;
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("wr_data", {12'd0, fAddr, fOut}, {12'd0, exp_q.pop_front()});
        end
        if (done) done_count = done_count + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_a();
        for (int k = 0; k < 16; k++) a_mem[k] = 16'd0;
    endtask

    task automatic push_wr(input logic [3:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic push_pass(input logic [15:0] f1 [0:5], input logic [15:0] f2 [0:5]);
        push_wr(4'd0, f1[0]);
        push_wr(4'd8, f2[0]);
        for (int k = 1; k < 6; k++) begin
            push_wr(4'(k), f1[k]);
            push_wr(4'(8 + k), f2[k]);
        end
    endtask

    // Pulse start and count cycles until done. Optionally re-pulse start
    // at cycle mid_start, or pull reset low at cycle abort_at.
    task automatic run_conv(input int mid_start, input int abort_at, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (mid_start != 0 && n == mid_start) begin
                check("mid_state_rd2", {28'd0, dbg_state}, {28'd0, RD2});
                start = 1'b1;
            end
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_aAddr", {28'd0, aAddr}, 32'd0);
                check("abort_fAddr", {28'd0, fAddr}, 32'd0);
                check("abort_fOut", {16'd0, fOut}, 32'd0);
                check("abort_fWrite", {31'd0, fWrite}, 32'd0);
                check("abort_ovf", {31'd0, ovf}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_state", {28'd0, dbg_state}, 32'd0);
                break;
            end
            if (done) break;
        end
        lat = n;
    endtask

    task automatic scenario(input string tag, input int mid_start, input int exp_lat,
                            input logic exp_ovf, input int exp_writes);
        int lat;
        int wr0;
        int d0;
        #1;
        wr0 = wr_count;
        d0  = done_count;
        run_conv(mid_start, 0, lat);
        check({tag, "_latency"}, lat, exp_lat);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({tag, "_exp_left"}, exp_q.size(), 32'd0);
        check({tag, "_writes"}, wr_count - wr0, exp_writes);
        check({tag, "_done_pulses"}, done_count - d0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] e1 [0:5];
        logic [15:0] e2 [0:5];
        int          lat;
        int          wr0;

        reset = 1'b0;
        start = 1'b0;
        clear_a();
        repeat (3) @(posedge clk);
        #1;
        check("rst_aAddr", {28'd0, aAddr}, 32'd0);
        check("rst_fAddr", {28'd0, fAddr}, 32'd0);
        check("rst_fOut", {16'd0, fOut}, 32'd0);
        check("rst_fWrite", {31'd0, fWrite}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // S1: all-zero LPC -> f1 alternates, f2 constant
        e1 = '{16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'hF800};
        e2 = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
        push_pass(e1, e2);
        scenario("s1", 0, 28, 1'b0, 12);

        // S2: a1=a10=-32768 -> overflow at i=0, /4 restart
        a_mem[1]  = 16'h8000;
        a_mem[10] = 16'h8000;
        push_wr(4'd0, 16'h0800);
        push_wr(4'd8, 16'h0800);
        e1 = '{16'h0400, 16'hBC00, 16'h4400, 16'hBC00, 16'h4400, 16'hBC00};
        e2 = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
        push_pass(e1, e2);
        scenario("s2", 0, 33, 1'b1, 14);

        // S3: a1=4096, a10=-4096 -> xs=0, xd=4096 at i=0
        clear_a();
        a_mem[1]  = 16'h1000;
        a_mem[10] = 16'hF000;
        e1 = '{16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'hF800};
        e2 = '{16'h0800, 16'h1800, 16'h1800, 16'h1800, 16'h1800, 16'h1800};
        push_pass(e1, e2);
        scenario("s3", 0, 28, 1'b0, 12);

        // S4: reset at cycle 10 (CALC of i=1): only the first four writes land
        clear_a();
        push_wr(4'd0, 16'h0800);
        push_wr(4'd8, 16'h0800);
        push_wr(4'd1, 16'hF800);
        push_wr(4'd9, 16'h0800);
        #1;
        wr0 = wr_count;
        run_conv(0, 10, lat);
        check("s4_abort_cycle", lat, 10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("s4_writes", wr_count - wr0, 4);
        check("s4_exp_left", exp_q.size(), 32'd0);
        check("s4_idle_state", {28'd0, dbg_state}, {28'd0, INIT});
        e1 = '{16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0800, 16'hF800};
        e2 = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
        push_pass(e1, e2);
        scenario("s4_rerun", 0, 28, 1'b0, 12);

        // S5: second start pulse during RD2 is ignored
        push_pass(e1, e2);
        scenario("s5", 4, 28, 1'b0, 12);

        // S6: overflow via f2 at i=0, then silent clamps with s=1
        clear_a();
        a_mem[1]  = 16'h7FFF;
        a_mem[10] = 16'h8000;
        a_mem[2]  = 16'h8000;
        a_mem[9]  = 16'h8000;
        a_mem[3]  = 16'h7FFF;
        a_mem[8]  = 16'h7FFF;
        a_mem[4]  = 16'h8000;
        a_mem[7]  = 16'h8000;
        a_mem[5]  = 16'h7FFF;
        a_mem[6]  = 16'h7FFF;
        push_wr(4'd0, 16'h0800);
        push_wr(4'd8, 16'h0800);
        e1 = '{16'h0400, 16'hFBFF, 16'hC401, 16'h7BFE, 16'h8000, 16'h7FFF};
        e2 = '{16'h0400, 16'h43FF, 16'h43FF, 16'h43FF, 16'h43FF, 16'h43FF};
        push_pass(e1, e2);
        scenario("s6", 0, 33, 1'b1, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
